// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, shift-bit counter width, longest chain supported.
package scan_ctrl_pkg;

  // The counter is 4 bits wide, so chains longer than 16 bits are not supported.
  localparam int CNT_W         = 4;
  localparam int MAX_CHAIN_LEN = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_COMPARE = 3'd4
  } scan_state_t;

  // Terminal count for a phase lasting n cycles. A zero-length phase wraps to
  // all-ones, which is harmless because such a phase is never entered.
  function automatic logic [CNT_W-1:0] last_idx(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/scan_test_controller_if.sv
// Signal bundle between a test host, the scan controller and the scanned DUT.
// Latency: n/a (wires only).
// Backpressure: none; START is only honoured while the controller is idle.
// master: host side (drives START/ABORT/PATTERN/EXPECT and the chain tail scan_out).
// slave : controller side (drives scan_enable/scan_in and BUSY/DONE/PASS/RESPONSE).
interface scan_test_controller_if #(
  parameter int CHAIN_LEN = 4
) ();

  logic                 START;
  logic                 ABORT;
  logic [CHAIN_LEN-1:0] PATTERN;
  logic [CHAIN_LEN-1:0] EXPECT;
  logic                 scan_enable;
  logic                 scan_in;
  logic                 scan_out;
  logic                 BUSY;
  logic                 DONE;
  logic                 PASS;
  logic [CHAIN_LEN-1:0] RESPONSE;

  modport master (
    output START, ABORT, PATTERN, EXPECT, scan_out,
    input  scan_enable, scan_in, BUSY, DONE, PASS, RESPONSE
  );

  modport slave (
    input  START, ABORT, PATTERN, EXPECT, scan_out,
    output scan_enable, scan_in, BUSY, DONE, PASS, RESPONSE
  );

endinterface

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register, shifting toward the MSB with serial in at the LSB.
// Latency: one CLK from load/shift to par_out/ser_out.
// Backpressure: none; load wins over shift.
// Ports: CLK, RESET (async active-low), load/load_val, shift/ser_in, par_out, ser_out (=MSB).
module scan_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out
);

  logic [WIDTH-1:0] q;

  // Shift written as a shift-and-or so a 1-bit register needs no special case.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= (q << 1) | WIDTH'(ser_in);
    end
  end

  assign par_out = q;
  assign ser_out = q[WIDTH-1];

endmodule

// File: rtl/scan_test_controller.sv
// Scan test sequencer: load PATTERN into the chain, pulse capture clocks, unload and compare.
// Latency: DONE rises 2*CHAIN_LEN+CAP_CYCLES+1 cycles after the launching START edge.
// Backpressure: START ignored while BUSY; ABORT returns to IDLE on the next edge.
// Ports: CLK, RESET (async active-low), bus (slave modport of scan_test_controller_if),
//        FAIL_CNT[7:0] only when SCAN_TEST_CONTROLLER_FAILCNT_EN is defined
//        (saturating count of failing compares).
module scan_test_controller
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 4,
  parameter int CAP_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  scan_test_controller_if.slave bus
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
  ,
  output logic [7:0]            FAIL_CNT
`endif
);

  localparam logic [CNT_W-1:0] LEN_LAST = last_idx(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CAP_LAST = last_idx(CAP_CYCLES);

  scan_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 launch;
  logic                 compare_fire;
  logic                 scan_enable_d, scan_enable_q;
  logic                 done_q, pass_q;
  logic [CHAIN_LEN-1:0] expect_q, response_q;
  logic                 ld_load;
  logic [CHAIN_LEN-1:0] ld_load_val;
  logic                 ld_ser;
  logic [CHAIN_LEN-1:0] ld_par_unused;
  logic [CHAIN_LEN-1:0] cap_q;
  logic                 cap_ser_unused;

  // Next state. ABORT is applied last so it overrides every transition,
  // including a launch from IDLE.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_LOAD;
          launch  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LEN_LAST) begin
          state_d = (CAP_CYCLES == 0) ? ST_UNLOAD : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == CAP_LAST) begin
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (cnt_q == LEN_LAST) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (bus.ABORT) begin
      state_d = ST_IDLE;
      launch  = 1'b0;
    end
  end

  // Counter restarts on every state change and is held at zero while idle,
  // so it never wraps within a phase.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end
  end

  // scan_enable is decided from the state being entered so the registered
  // value lines up with the cycle it belongs to.
  assign scan_enable_d = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
  assign compare_fire  = (state_q == ST_COMPARE) && !bus.ABORT;

  // Stimulus register: its MSB is scan_in. After CHAIN_LEN shifts it holds
  // zeros, which keeps scan_in low through capture/unload; ABORT reloads zeros
  // so a cut-short load does not leave a stimulus bit on the line.
  assign ld_load     = launch || bus.ABORT;
  assign ld_load_val = launch ? bus.PATTERN : '0;

  scan_shift_reg #(
    .WIDTH (CHAIN_LEN)
  ) u_load_sr (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (ld_load),
    .load_val (ld_load_val),
    .shift    (state_q == ST_LOAD),
    .ser_in   (1'b0),
    .par_out  (ld_par_unused),
    .ser_out  (ld_ser)
  );

  // Response register: the first bit sampled ends up in the MSB.
  scan_shift_reg #(
    .WIDTH (CHAIN_LEN)
  ) u_unload_sr (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (launch),
    .load_val ('0),
    .shift    (state_q == ST_UNLOAD),
    .ser_in   (bus.scan_out),
    .par_out  (cap_q),
    .ser_out  (cap_ser_unused)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      scan_enable_q <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      expect_q      <= '0;
      response_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scan_enable_q <= scan_enable_d;
      done_q        <= compare_fire;
      if (launch) begin
        expect_q <= bus.EXPECT;
      end
      if (compare_fire) begin
        response_q <= cap_q;
        pass_q     <= (cap_q == expect_q);
      end
    end
  end

`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
  logic [7:0] fail_cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fail_cnt_q <= '0;
    end else if (compare_fire && (cap_q != expect_q) && (fail_cnt_q != 8'hFF)) begin
      fail_cnt_q <= fail_cnt_q + 8'd1;
    end
  end

  assign FAIL_CNT = fail_cnt_q;
`endif

  assign bus.scan_enable = scan_enable_q;
  assign bus.scan_in     = ld_ser;
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.DONE        = done_q;
  assign bus.PASS        = pass_q;
  assign bus.RESPONSE    = response_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: two instances (CAP_CYCLES=1 and 0), each with its
// scan_in looped back to scan_out through a CHAIN_LEN-bit chain model.
// Optional FAIL_CNT checks follow SCAN_TEST_CONTROLLER_FAILCNT_EN.
module tb_scan_test_controller;

  localparam int N  = 4;
  localparam int CA = 1;
  localparam int CB = 0;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  scan_test_controller_if #(.CHAIN_LEN(N)) bus_a ();
  scan_test_controller_if #(.CHAIN_LEN(N)) bus_b ();

  // Chain under test: a plain N-bit shift register clocked while scan_enable is high.
  logic [N-1:0] chain_a = '0;
  logic [N-1:0] chain_b = '0;
  always @(posedge CLK) if (bus_a.scan_enable) chain_a <= {chain_a[N-2:0], bus_a.scan_in};
  always @(posedge CLK) if (bus_b.scan_enable) chain_b <= {chain_b[N-2:0], bus_b.scan_in};
  assign bus_a.scan_out = chain_a[N-1];
  assign bus_b.scan_out = chain_b[N-1];

`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
  logic [7:0] fail_cnt_a, fail_cnt_b;
  int m_fcnt_a = 0;
  int m_fcnt_b = 0;
`endif

  scan_test_controller #(.CHAIN_LEN(N), .CAP_CYCLES(CA)) dut_a (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_a)
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
    , .FAIL_CNT (fail_cnt_a)
`endif
  );

  scan_test_controller #(.CHAIN_LEN(N), .CAP_CYCLES(CB)) dut_b (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_b)
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
    , .FAIL_CNT (fail_cnt_b)
`endif
  );

  // Reference state: last reported response/pass per instance.
  logic [N-1:0] m_resp_a = '0;
  logic         m_pass_a = 1'b0;
  logic [N-1:0] m_resp_b = '0;
  logic         m_pass_b = 1'b0;

  // The chain is a FIFO of depth N: bits go in MSB first during load and come
  // out in the same order during unload, first out landing in the MSB.
  function automatic logic [N-1:0] loopback(input logic [N-1:0] pat);
    bit fifo[$];
    logic [N-1:0] r;
    r = '0;
    for (int b = N - 1; b >= 0; b--) fifo.push_back(pat[b]);
    for (int j = 0; j < N; j++) r[N-1-j] = fifo.pop_front();
    return r;
  endfunction

  task automatic test_reset();
    RESET = 1'b0;
    bus_a.START = 1'b0; bus_a.ABORT = 1'b0; bus_a.PATTERN = '0; bus_a.EXPECT = '0;
    bus_b.START = 1'b0; bus_b.ABORT = 1'b0; bus_b.PATTERN = '0; bus_b.EXPECT = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus_a.BUSY, bus_a.DONE, bus_a.PASS, bus_a.scan_enable, bus_a.scan_in, bus_a.RESPONSE} !== '0) begin
      errors++;
      $display("FAIL reset_a got busy/done/pass/se/si/resp=%b%b%b%b%b/%b want all zero",
               bus_a.BUSY, bus_a.DONE, bus_a.PASS, bus_a.scan_enable, bus_a.scan_in, bus_a.RESPONSE);
    end
    checks++;
    if ({bus_b.BUSY, bus_b.DONE, bus_b.PASS, bus_b.scan_enable, bus_b.scan_in, bus_b.RESPONSE} !== '0) begin
      errors++;
      $display("FAIL reset_b got busy/done/pass/se/si/resp=%b%b%b%b%b/%b want all zero",
               bus_b.BUSY, bus_b.DONE, bus_b.PASS, bus_b.scan_enable, bus_b.scan_in, bus_b.RESPONSE);
    end
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
    checks++;
    if ({fail_cnt_a, fail_cnt_b} !== 16'h0) begin
      errors++;
      $display("FAIL reset_failcnt got %0d/%0d want 0/0", fail_cnt_a, fail_cnt_b);
    end
`endif
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus_a.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b want 0", bus_a.BUSY);
    end
  endtask

  // One full run on instance A; PATTERN/EXPECT are scrambled after launch to
  // confirm they were latched, and with noise START toggles while busy.
  task automatic run_a(input logic [N-1:0] pat, input logic [N-1:0] exp_v, input bit noise);
    int last;
    logic [3:0] got, want;
    last = 2 * N + CA + 1;
    @(negedge CLK);
    bus_a.PATTERN = pat; bus_a.EXPECT = exp_v; bus_a.START = 1'b1;
    for (int i = 0; i <= last; i++) begin
      @(negedge CLK);
      want[3] = (i < last);
      want[2] = (i == last);
      want[1] = (i < N) || ((i >= N + CA) && (i < 2 * N + CA));
      want[0] = (i < N) ? pat[N-1-i] : 1'b0;
      got = {bus_a.BUSY, bus_a.DONE, bus_a.scan_enable, bus_a.scan_in};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL run_timeline pat=%b cyc=%0d got busy/done/se/si=%b want %b", pat, i, got, want);
      end
      bus_a.PATTERN = N'($urandom);
      bus_a.EXPECT  = N'($urandom);
      bus_a.START   = (noise && i < last) ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    m_resp_a = loopback(pat);
    m_pass_a = (m_resp_a == exp_v);
    checks++;
    if ({bus_a.RESPONSE, bus_a.PASS} !== {m_resp_a, m_pass_a}) begin
      errors++;
      $display("FAIL run_result pat=%b exp=%b got resp=%b pass=%b want resp=%b pass=%b",
               pat, exp_v, bus_a.RESPONSE, bus_a.PASS, m_resp_a, m_pass_a);
    end
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
    if (!m_pass_a && m_fcnt_a < 255) m_fcnt_a++;
    checks++;
    if (fail_cnt_a !== 8'(m_fcnt_a)) begin
      errors++;
      $display("FAIL run_failcnt got %0d want %0d", fail_cnt_a, m_fcnt_a);
    end
`endif
  endtask

  task automatic test_directed();
    run_a(4'b1011, 4'b1011, 1'b0);
    run_a(4'b1011, 4'b1010, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] p, e;
    for (int k = 0; k < 16; k++) begin
      p = N'($urandom);
      e = ($urandom_range(1, 0) == 1) ? p : N'($urandom);
      run_a(p, e, k[0]);
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] p;
    p = N'($urandom);
    @(negedge CLK);
    bus_a.PATTERN = p; bus_a.EXPECT = p; bus_a.START = 1'b1;
    for (int i = 0; i <= N + CA + 1; i++) begin
      @(negedge CLK);
      bus_a.START = 1'b0;
      checks++;
      if (bus_a.BUSY !== 1'b1) begin
        errors++;
        $display("FAIL abort_prerun cyc=%0d got busy=%b want 1", i, bus_a.BUSY);
      end
    end
    bus_a.ABORT = 1'b1;
    @(negedge CLK);
    bus_a.ABORT = 1'b0;
    checks++;
    if ({bus_a.BUSY, bus_a.DONE, bus_a.scan_enable, bus_a.scan_in} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle got busy/done/se/si=%b%b%b%b want 0000",
               bus_a.BUSY, bus_a.DONE, bus_a.scan_enable, bus_a.scan_in);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      checks++;
      if (bus_a.DONE !== 1'b0 || bus_a.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done cyc=%0d got done=%b busy=%b want 0 0", i, bus_a.DONE, bus_a.BUSY);
      end
    end
    checks++;
    if ({bus_a.RESPONSE, bus_a.PASS} !== {m_resp_a, m_pass_a}) begin
      errors++;
      $display("FAIL abort_hold got resp=%b pass=%b want resp=%b pass=%b",
               bus_a.RESPONSE, bus_a.PASS, m_resp_a, m_pass_a);
    end
    bus_a.START = 1'b1; bus_a.ABORT = 1'b1;
    @(negedge CLK);
    bus_a.START = 1'b0; bus_a.ABORT = 1'b0;
    checks++;
    if (bus_a.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start got busy=%b want 0", bus_a.BUSY);
    end
  endtask

  task automatic test_reset_midrun();
    logic [N-1:0] p;
    p = N'($urandom);
    @(negedge CLK);
    bus_a.PATTERN = p; bus_a.EXPECT = p; bus_a.START = 1'b1;
    for (int i = 0; i <= N; i++) begin
      @(negedge CLK);
      bus_a.START = 1'b0;
    end
    checks++;
    if ({bus_a.BUSY, bus_a.scan_enable} !== 2'b10) begin
      errors++;
      $display("FAIL capture_phase got busy/se=%b%b want 10", bus_a.BUSY, bus_a.scan_enable);
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({bus_a.BUSY, bus_a.DONE, bus_a.PASS, bus_a.scan_enable, bus_a.scan_in, bus_a.RESPONSE} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy/done/pass/se/si/resp=%b%b%b%b%b/%b want all zero",
               bus_a.BUSY, bus_a.DONE, bus_a.PASS, bus_a.scan_enable, bus_a.scan_in, bus_a.RESPONSE);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    m_resp_a = '0; m_pass_a = 1'b0; m_resp_b = '0; m_pass_b = 1'b0;
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
    m_fcnt_a = 0; m_fcnt_b = 0;
`endif
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      checks++;
      if (bus_a.DONE !== 1'b0 || bus_a.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done cyc=%0d got done=%b busy=%b want 0 0", i, bus_a.DONE, bus_a.BUSY);
      end
    end
    p = N'($urandom);
    run_a(p, p, 1'b0);
  endtask

  // START held for 30 edges on the CAP_CYCLES=0 instance: runs of 2N+1 = 9 cycles,
  // DONE in the single idle cycle, then straight back into LOAD.
  task automatic test_back_to_back();
    logic [N-1:0] pb, eb;
    logic [3:0] got, want;
    int r;
    pb = N'($urandom);
    eb = ($urandom_range(1, 0) == 1) ? pb : N'($urandom);
    @(negedge CLK);
    bus_b.PATTERN = pb; bus_b.EXPECT = eb; bus_b.START = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      r = i % 10;
      want[3] = (r < 9);
      want[2] = (r == 9);
      want[1] = (r < 2 * N);
      want[0] = (r < N) ? pb[N-1-r] : 1'b0;
      got = {bus_b.BUSY, bus_b.DONE, bus_b.scan_enable, bus_b.scan_in};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_timeline cyc=%0d got busy/done/se/si=%b want %b", i, got, want);
      end
      if (r == 9) begin
        m_resp_b = loopback(pb);
        m_pass_b = (m_resp_b == eb);
        checks++;
        if ({bus_b.RESPONSE, bus_b.PASS} !== {m_resp_b, m_pass_b}) begin
          errors++;
          $display("FAIL b2b_result cyc=%0d got resp=%b pass=%b want resp=%b pass=%b",
                   i, bus_b.RESPONSE, bus_b.PASS, m_resp_b, m_pass_b);
        end
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
        if (!m_pass_b && m_fcnt_b < 255) m_fcnt_b++;
`endif
        pb = N'($urandom);
        eb = ($urandom_range(1, 0) == 1) ? pb : N'($urandom);
        bus_b.PATTERN = pb; bus_b.EXPECT = eb;
      end
    end
    bus_b.START = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus_b.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop got busy=%b want 0", bus_b.BUSY);
    end
  endtask

`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
  task automatic test_fail_saturate();
    int dones;
    logic [N-1:0] x;
    dones = 0;
    bus_b.START = 1'b1;
    for (int i = 0; i < 3000 && dones < 260; i++) begin
      @(negedge CLK);
      if (bus_b.DONE === 1'b1) begin
        dones++;
        if (dones == 260) bus_b.START = 1'b0;
      end
      x = N'($urandom);
      bus_b.PATTERN = x; bus_b.EXPECT = ~x;
    end
    bus_b.START = 1'b0;
    checks++;
    if (dones != 260) begin
      errors++;
      $display("FAIL sat_runs got %0d done pulses want 260", dones);
    end
    m_fcnt_b = (m_fcnt_b + 260 > 255) ? 255 : m_fcnt_b + 260;
    @(negedge CLK);
    checks++;
    if (fail_cnt_b !== 8'(m_fcnt_b)) begin
      errors++;
      $display("FAIL sat_failcnt got %0d want %0d", fail_cnt_b, m_fcnt_b);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
`ifdef SCAN_TEST_CONTROLLER_FAILCNT_EN
    test_fail_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_test_controller.md
SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

Interface
REQ-001 Parameter CHAIN_LEN, default 4, scan chain length in bits (legal 1..16); also sets the PATTERN, EXPECT and RESPONSE widths.
REQ-002 Parameter CAP_CYCLES, default 1, number of functional (capture) clocks between load and unload (legal 0..15).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  sampled only in IDLE; 1 launches a test run.
REQ-006 ABORT  in  1  synchronous; 1 terminates any run and returns to IDLE.
REQ-007 PATTERN  in  CHAIN_LEN  stimulus to shift into the chain; captured at launch.
REQ-008 EXPECT  in  CHAIN_LEN  expected unload value; captured at launch.
REQ-009 scan_enable  out  1  drives the DUT scan_enable.
REQ-010 scan_in  out  1  drives the DUT scan_in.
REQ-011 scan_out  in  1  DUT scan_out, chain tail.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 DONE  out  1  one-cycle pulse when a run completes.
REQ-014 PASS  out  1  RESPONSE==EXPECT for the last completed run; held until the next DONE.
REQ-015 RESPONSE  out  CHAIN_LEN  last unloaded chain contents; held until the next DONE.

Function
REQ-016 FSM states: IDLE, LOAD, CAPTURE, UNLOAD, COMPARE.
REQ-017 IDLE with START=1 at a rising edge: PATTERN and EXPECT are latched, and the FSM goes to LOAD.
REQ-018 LOAD lasts exactly CHAIN_LEN cycles, with scan_enable=1 and scan_in=latched PATTERN bit, MSB first (bit CHAIN_LEN-1 in the first cycle).
REQ-019 After LOAD the FSM goes to CAPTURE for CAP_CYCLES cycles with scan_enable=0 and scan_in=0; CAP_CYCLES=0 goes straight from LOAD to UNLOAD.
REQ-020 UNLOAD lasts exactly CHAIN_LEN cycles, with scan_enable=1 and scan_in=0; scan_out is sampled at each rising edge that ends an UNLOAD cycle and shifted into a CHAIN_LEN-bit register from the LSB end, so the first sample becomes RESPONSE MSB.
REQ-021 COMPARE lasts one cycle: it updates RESPONSE and PASS, asserts DONE, then returns to IDLE.
REQ-022 Total latency from the START edge to DONE high is 2*CHAIN_LEN+CAP_CYCLES+1 cycles.
REQ-023 START outside IDLE is ignored; START held high re-launches on the first IDLE cycle after DONE.
REQ-024 ABORT has priority over START and all state transitions: the FSM goes to IDLE next edge with scan_enable=0, no DONE, and RESPONSE/PASS unchanged.
REQ-025 The shift-bit counter is 4 bits wide, counts 0..CHAIN_LEN-1 and is cleared on every state entry; it never wraps inside a state.
REQ-026 scan_enable and scan_in are registered outputs (glitch-free).

Reset
REQ-027 RESET low asynchronously forces: IDLE, scan_enable=0, scan_in=0, BUSY=0, DONE=0, PASS=0, RESPONSE=0, counters=0.
REQ-028 Reset asserted mid-run abandons the run; no DONE pulse is produced after reset is released.

Configuration
REQ-029 Macro SCAN_TEST_CONTROLLER_FAILCNT_EN defined: adds output FAIL_CNT [7:0], which increments at each COMPARE with PASS=0, saturates at 255 and resets to 0.
REQ-030 Macro undefined: there is no FAIL_CNT port and no counter logic; all other behaviour is identical.

Structure
REQ-031 Package scan_ctrl_pkg holds the FSM state typedef, the counter width constant (4) and the maximum CHAIN_LEN constant (16).
REQ-032 One sub-module, scan_shift_reg: a CHAIN_LEN-bit parallel-load shift register with serial out (load) and serial in (unload), instantiated twice.

Verification
REQ-033 CHAIN_LEN=4, CAP_CYCLES=1, scan_in looped to scan_out through a 4-bit shift register, PATTERN=4'b1011, EXPECT=4'b1011, START pulse -> scan_in sequence 1,0,1,1; DONE 10 cycles after START; RESPONSE=4'b1011; PASS=1.
REQ-034 Same setup, EXPECT=4'b1010 -> PASS=0, RESPONSE=4'b1011; FAIL_CNT=1 when SCAN_TEST_CONTROLLER_FAILCNT_EN is defined.
REQ-035 ABORT asserted in the 2nd UNLOAD cycle -> IDLE next cycle, scan_enable=0, no DONE, RESPONSE keeps its prior value.
REQ-036 RESET low during CAPTURE -> all outputs zero immediately (asynchronously); START after release runs a full, correct sequence.
REQ-037 CAP_CYCLES=0 with START held high for 30 cycles -> back-to-back runs each 9 cycles long, with exactly one idle cycle between DONE and the next LOAD.
REQ-038 Failing-run count driven to 260 with the macro defined -> FAIL_CNT stays at 255.
